// File: rtl/seg7_reader_pkg.sv
// Shared definitions for the seven-segment reader.
// Glyph constants match the seg7 encoder so encode and decode agree.
package seg7_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    EMIT,
    HOLD
  } state_t;

  // Segment order: bit0=a ... bit6=g
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// Combinational glyph decoder: segment pattern to hex digit.
// Any pattern outside the glyph set reports legal=0.
module seg7_decode
  import seg7_reader_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       legal
);

  always_comb begin
    digit = 4'h0;
    legal = 1'b1;
    unique case (pattern)
      GLYPH_0: digit = 4'h0;
      GLYPH_1: digit = 4'h1;
      GLYPH_2: digit = 4'h2;
      GLYPH_3: digit = 4'h3;
      GLYPH_4: digit = 4'h4;
      GLYPH_5: digit = 4'h5;
      GLYPH_6: digit = 4'h6;
      GLYPH_7: digit = 4'h7;
      GLYPH_8: digit = 4'h8;
      GLYPH_9: digit = 4'h9;
      GLYPH_A: digit = 4'hA;
      GLYPH_B: digit = 4'hB;
      GLYPH_C: digit = 4'hC;
      GLYPH_D: digit = 4'hD;
      GLYPH_E: digit = 4'hE;
      GLYPH_F: digit = 4'hF;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Reads a multiplexed-free 7-segment display: debounces glyphs,
// decodes them to hex digits and pairs digits into bytes.
module seg7_reader
  import seg7_reader_pkg::*;
#(
  parameter int STABLE_CYCLES  = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  output logic [3:0] digit_out,
  output logic       digit_valid,
  output logic       seg_error,
  output logic [7:0] byte_out,
  output logic       byte_valid
);

  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  // The IDLE capture cycle already counts as one stable cycle
  localparam logic [CW-1:0] SETTLE_LAST = CW'(STABLE_CYCLES - 2);
  localparam logic [CW-1:0] HOLD_LAST = CW'(STABLE_CYCLES - 1);

  logic [6:0] seg_raw;
  logic [6:0] sync1;
  logic [6:0] sync2;

  state_t state;
  state_t state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] cnt_inc;
  logic [6:0] cap;
  logic [6:0] cap_nxt;

  logic blank;
  logic same;
  logic [3:0] dec_digit;
  logic dec_legal;

  logic pair;
  logic [3:0] high;

  assign seg_raw = SEG_ACTIVE_LOW ? ~seg_in : seg_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= seg_raw;
      sync2 <= sync1;
    end
  end

  seg7_decode u_decode (
    .pattern (cap),
    .digit   (dec_digit),
    .legal   (dec_legal)
  );

  assign blank = (sync2 == SEG_BLANK);
  assign same = (sync2 == cap);
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    cap_nxt = cap;
    unique case (state)
      IDLE: begin
        if (!blank) begin
          cap_nxt = sync2;
          cnt_nxt = '0;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (blank) begin
          cnt_nxt = '0;
          state_nxt = IDLE;
        end else if (!same) begin
          cap_nxt = sync2;
          cnt_nxt = '0;
        end else if (cnt >= SETTLE_LAST) begin
          state_nxt = EMIT;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      EMIT: begin
        cnt_nxt = '0;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (!blank) begin
          cnt_nxt = '0;
        end else if (cnt >= HOLD_LAST) begin
          cnt_nxt = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        cnt_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cap <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      cap <= cap_nxt;
    end
  end

  // EMIT is a single cycle, so every pulse is isolated
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_out <= '0;
      digit_valid <= 1'b0;
      seg_error <= 1'b0;
      byte_out <= '0;
      byte_valid <= 1'b0;
      pair <= 1'b0;
      high <= '0;
    end else begin
      digit_valid <= 1'b0;
      seg_error <= 1'b0;
      byte_valid <= 1'b0;
      if (state == EMIT) begin
        if (dec_legal) begin
          digit_out <= dec_digit;
          digit_valid <= 1'b1;
          if (pair) begin
            byte_out <= {high, dec_digit};
            byte_valid <= 1'b1;
            pair <= 1'b0;
          end else begin
            high <= dec_digit;
            pair <= 1'b1;
          end
        end else begin
          seg_error <= 1'b1;
          pair <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1000: cycles a pattern must hold unchanged before it is accepted (minimum 2).
REQ-002 SHALL have parameter SEG_ACTIVE_LOW, default 0: 1 = inputs are inverted before any processing.
REQ-003 SHALL use one clock and asynchronous active-high reset, exactly as follows:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have these data ports:
- seg_in  input  7  segment lines, bit0=a … bit6=g, asynchronous to clk.
- digit_out  output  4  last accepted hex digit.
- digit_valid  output  1  one-cycle pulse when digit_out updates.
- seg_error  output  1  one-cycle pulse when an accepted pattern is not a legal hex glyph.
- byte_out  output  8  last assembled byte, first digit in [7:4].
- byte_valid  output  1  one-cycle pulse when byte_out updates.

Function
REQ-005 SHALL pass seg_in through a 2-flop synchronizer (after optional inversion) before any other use.
REQ-006 SHALL decode these glyphs (hex pattern -> digit): 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->A, 7C->b, 39->C, 5E->d, 79->E, 71->F.
REQ-007 SHALL treat 00 as blank, the inter-digit separator.
REQ-008 SHALL treat every other non-blank pattern as illegal.
REQ-009 SHALL implement FSM states IDLE, SETTLE, EMIT, HOLD.
REQ-010 IDLE: on a non-blank synced pattern, capture it, clear the stability counter, go to SETTLE.
REQ-011 SETTLE, pattern differs from captured and is non-blank: SHALL recapture and clear the counter (glitch rejection).
REQ-012 SETTLE, pattern is blank: SHALL return to IDLE without any output.
REQ-013 SETTLE: once the pattern has equalled the capture for STABLE_CYCLES consecutive cycles, SHALL go to EMIT.
REQ-014 EMIT lasts exactly one cycle and then goes to HOLD.
- Legal capture: SHALL update digit_out and pulse digit_valid.
- Illegal capture: SHALL pulse seg_error and leave digit_out unchanged.
REQ-015 HOLD: SHALL ignore all non-blank patterns and return to IDLE only after blank holds STABLE_CYCLES consecutive cycles; a repeated glyph therefore requires an intervening blank.
REQ-016 Latency from a seg_in change to the digit_valid pulse SHALL be 2 + STABLE_CYCLES + 1 cycles.
REQ-017 SHALL pair accepted digits.
- First digit: stored as the high nibble; the pair flag is set.
- Second digit: byte_out = {high, digit}; byte_valid pulses in the same cycle as that digit's digit_valid; the pair flag clears.
REQ-018 seg_error SHALL clear the pair flag, discarding any half-assembled byte.
REQ-019 The stability counter SHALL saturate and SHALL NOT wrap; its width is clog2(STABLE_CYCLES)+1.
REQ-020 digit_valid, seg_error and byte_valid SHALL be registered, and never asserted for two consecutive cycles.

Reset
REQ-021 Asserting rst SHALL immediately force:
- state=IDLE; synchronizer, counter, capture and pair flag cleared;
- digit_out=0, byte_out=0, and all pulses 0.
REQ-022 Reset asserted mid-SETTLE or mid-HOLD SHALL abandon the capture; the first post-reset digit starts a new pair.
REQ-023 Deassertion SHALL be synchronized by the integrating top level; the block adds no reset logic of its own.

Structure
REQ-024 A shared package SHALL hold:
- the FSM state enum;
- the 16 glyph constants, shared with the existing seg7 encoder so that encode/decode stay matched;
- the blank constant.
REQ-025 SHALL contain one sub-module, seg7_decode: combinational, 7-bit pattern in -> 4-bit digit plus legal flag.
REQ-026 Target size 120-400 lines of RTL.

Verification (STABLE_CYCLES=4)
REQ-027 After reset, drive 6D, hold 10 cycles -> exactly one digit_valid with digit_out=5, at cycle 7 after the change.
REQ-028 Drive 4F, blank 6 cycles, 06 -> digit_valid twice (3, then 1); byte_valid once with byte_out=8'h31.
REQ-029 Alternate 3F/06 every 2 cycles for 20 cycles, then hold 06 -> no pulses during toggling; one digit_valid with digit_out=1.
REQ-030 Drive 7D, blank, 01 (illegal), blank, 77 -> digit_valid (6), then seg_error with digit_out still 6, then digit_valid (A); no byte_valid.
REQ-031 Hold 79 for 50 cycles, blank 2 cycles, 79 again -> only one digit_valid (blank shorter than STABLE_CYCLES).
REQ-032 Assert rst during SETTLE of 5B -> all outputs 0 immediately; after release, 5B, blank, 66 -> byte_out=8'h24.
